// File: rtl/alu_pkg.sv
// Shared product format, accumulator FSM states and sign-magnitude conversion.
// Used by the accumulator top and its saturating adder.
package alu_pkg;

  localparam int PROD_W   = 5;
  localparam int SIGN_BIT = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Negative zero falls out as 0 because -0 == 0 in two's complement.
  function automatic logic signed [PROD_W-1:0] sm_to_tc(input logic [PROD_W-1:0] sm);
    logic signed [PROD_W-1:0] mag;
    mag = {1'b0, sm[SIGN_BIT-1:0]};
    return sm[SIGN_BIT] ? -mag : mag;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Saturating add of a W-bit accumulator and a 5-bit signed product.
// Purely combinational, zero latency, no backpressure.
module sat_add
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic signed [W-1:0]      a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [W-1:0]      sum,
  output logic                     sat
);

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic signed [W:0] wide;

  always_comb begin
    a_ext = {a[W-1], a};
    b_ext = {{(W-PROD_W+1){b[PROD_W-1]}}, b};
    wide  = a_ext + b_ext;
    // The two top bits disagree only when the true sum left the W-bit range.
    sat   = wide[W] ^ wide[W-1];
    if (!sat)
      sum = wide[W-1:0];
    else if (wide[W])
      sum = MIN_VAL;
    else
      sum = MAX_VAL;
  end

endmodule

// File: rtl/mul_accumulator.sv
// Accumulates bursts of sign-magnitude products with saturation; result and flags in HOLD.
// Result valid the cycle after the final accept; in_ready drops while a result waits on out_ready.
module mul_accumulator
  import alu_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_r,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sf,
  output logic              out_zf,
  output logic              out_of
);

  // Count value just before the accept that must close the burst.
  localparam logic [CNT_W-1:0] CNT_END_M1 = {{(CNT_W-1){1'b1}}, 1'b0};

  acc_state_e               state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     of_q;
  logic                     in_ready_q;
  logic                     out_valid_q;

  logic signed [PROD_W-1:0] prod_tc;
  logic signed [ACC_W-1:0]  sum;
  logic                     sat;
  logic                     accept;
  logic                     burst_end;

  assign prod_tc   = sm_to_tc(in_r);
  assign accept    = in_valid && in_ready_q;
  assign burst_end = in_last || (cnt == CNT_END_M1);

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (prod_tc),
    .sum (sum),
    .sat (sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      // Clear wins over any simultaneous accept or consume.
      state       <= ACCUM;
      acc         <= '0;
      cnt         <= '0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc  <= sum;
            cnt  <= cnt + CNT_W'(1);
            of_q <= of_q | sat;
            if (burst_end) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            of_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc;
  assign out_cnt   = cnt;
  assign out_of    = of_q;
  assign out_sf    = acc[ACC_W-1];
  assign out_zf    = (acc == '0);

endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
- Downstream consumer of the 3-bit sign-magnitude multiplier result.
- Accepts 5-bit sign-magnitude products (bit 4 = sign, bits 3:0 = magnitude) over a valid/ready handshake.
- Converts each product to two's complement and accumulates a burst with saturation.
- Presents the final sum, product count and SF/ZF/OF flags over an output valid/ready handshake.

Parameters:
- ACC_W, 8: accumulator width, signed two's complement; legal 6..16.
- CNT_W, 4: product-counter width; a burst ends automatically after 2^CNT_W-1 accepted products.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- clr  in  1  synchronous clear; aborts the current burst
- in_valid  in  1  product available
- in_ready  out  1  block can accept a product
- in_r  in  5  sign-magnitude product; [4] sign, [3:0] magnitude
- in_last  in  1  qualifies in_r as the final product of the burst
- out_valid  out  1  burst result available
- out_ready  in  1  consumer takes the result
- out_acc  out  ACC_W  accumulated sum, two's complement
- out_cnt  out  CNT_W  number of products in the burst
- out_sf  out  1  out_acc[ACC_W-1]
- out_zf  out  1  out_acc == 0
- out_of  out  1  saturation occurred during the burst (sticky)

Behaviour:
- Clock and reset (decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=ACCUM, acc=0, cnt=0, of=0, out_valid=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first edge after release.
  - Reset mid-burst discards everything.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at a rising edge.
- Conversion:
  - v = sign ? -mag : +mag, 5-bit signed, range -15..+15.
  - Negative zero (5'b10000) yields 0.
  - Magnitudes 10..15 are accepted arithmetically, not flagged.
- Add:
  - sum = acc + sign-extended v, computed at ACC_W+1 bits.
  - sum > 2^(ACC_W-1)-1 clamps to the max; sum < -2^(ACC_W-1) clamps to the min.
  - Either clamp sets of; of stays set until the burst is consumed or cleared.
- Counter: cnt increments on every accept.
- Latency:
  - The accept edge updates acc/cnt/of, visible the next cycle.
  - If in_last=1, or cnt was 2^CNT_W-2 before the accept, the same edge moves ACCUM->HOLD.
  - out_valid is high in the cycle after the final accept.
- HOLD:
  - out_acc/out_cnt/out_sf/out_zf/out_of are stable while out_valid & !out_ready.
  - in_valid is ignored.
  - On out_valid & out_ready: HOLD->ACCUM, and acc, cnt, of clear to 0.
  - A new product can be accepted the following cycle; no same-cycle bypass.
- clr:
  - In any state: next edge gives state=ACCUM, acc=cnt=of=0, out_valid=0.
  - clr beats a simultaneous accept; that product is dropped.
  - clr beats a simultaneous out_ready; the result is lost.
- Outputs outside HOLD:
  - out_acc/out_cnt/out_of show the running registers; SF/ZF are derived from them.
  - All are only meaningful when out_valid=1.
- Flags: out_sf and out_zf are combinational from the acc register, so there is no extra latency.
- The in_last/counter-end cause is not distinguished at the output.

Decomposition:
- Shared package alu_pkg:
  - Product width constant PROD_W=5 and SIGN_BIT=4.
  - State enum {ACCUM, HOLD}.
  - Function sm_to_tc(5-bit sm) returning a 5-bit signed value.
- One sub-module sat_add:
  - Parameter W.
  - Inputs: W-bit signed a, 5-bit signed b.
  - Outputs: W-bit saturated sum and a sat flag.
  - Purely combinational, instantiated once.
- FSM, counter and registers stay in mul_accumulator.

Test Plan:
1. Reset: hold rst_n=0 mid-stream with in_valid=1 -> in_ready=0, out_valid=0; after release out_acc=0, out_cnt=0, in_ready=1 next cycle.
2. Burst +9 (01001), -4 (10100), +6 (00110, in_last) -> one cycle later out_valid=1, out_acc=11, out_cnt=3, SF=0, ZF=0, OF=0.
3. Single 5'b10000 with in_last -> out_acc=0, ZF=1, SF=0, out_cnt=1. Then -9,+2 last -> out_acc=-7 (8'hF9), SF=1.
4. ACC_W=8, fifteen products of -9, no in_last:
   - After 14 products acc=-126.
   - 15th product gives out_acc=-128 (8'h80), OF=1, out_cnt=15, and out_valid rises via counter end.
5. Backpressure: in HOLD, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs constant. Then out_ready=1 -> next cycle out_valid=0, acc=0, and the pending product is accepted the cycle after.
6. clr asserted in the same cycle as an accepted +5, mid-burst (acc=7) -> next cycle acc=0, cnt=0, OF=0, state ACCUM, the +5 is not counted.
